// File: rtl/reg_file_wb_arbiter.sv
// Register-file write-port arbiter: loads always win, displaced ALU results
// wait in an in-order circular queue whose live entries drive a busy mask.
module reg_file_wb_arbiter #(
  parameter int QDEPTH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      w_alu_valid,
  input  logic [ADDR_W-1:0]         w_alu_waddr,
  input  logic [DATA_W-1:0]         w_alu_wdata,
  input  logic                      w_ld_valid,
  input  logic [ADDR_W-1:0]         w_ld_waddr,
  input  logic [DATA_W-1:0]         w_ld_wdata,
  output logic                      w_alu_stall,
  output logic                      w_rf_wen,
  output logic [ADDR_W-1:0]         w_rf_waddr,
  output logic [DATA_W-1:0]         w_rf_wdata,
  output logic [2**ADDR_W-1:0]      w_busy_mask,
  output logic [$clog2(QDEPTH):0]   w_q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  logic [ADDR_W-1:0] q_addr_reg [QDEPTH];
  logic [DATA_W-1:0] q_data_reg [QDEPTH];
  logic [QDEPTH-1:0] q_live_reg;
  logic [QDEPTH-1:0] q_live_next;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic ld_go;
  logic alu_go;
  logic q_nonempty;
  logic enq;
  logic deq;

  // Writes to r0 are architecturally discarded, so they never reach the port or queue.
  assign ld_go       = w_ld_valid && (w_ld_waddr != '0);
  assign w_alu_stall = (count_reg == CNT_W'(QDEPTH));
  assign alu_go      = w_alu_valid && !w_alu_stall && (w_alu_waddr != '0);
  assign q_nonempty  = (count_reg != '0);
  assign enq         = alu_go && (ld_go || q_nonempty);
  assign deq         = !ld_go && q_nonempty;
  assign w_q_count   = count_reg;

  // A same-cycle ALU result is younger than the load, so the new tail entry
  // takes priority over the squash compare.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_live
      assign q_live_next[gi] =
        (enq && (tail_reg == PTR_W'(gi))) ? 1'b1 :
        (deq && (head_reg == PTR_W'(gi))) ? 1'b0 :
        (ld_go && (q_addr_reg[gi] == w_ld_waddr)) ? 1'b0 :
        q_live_reg[gi];
    end
  endgenerate

  always_comb begin
    w_busy_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_live_reg[i]) begin
        w_busy_mask[q_addr_reg[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      q_addr_reg[tail_reg] <= w_alu_waddr;
      q_data_reg[tail_reg] <= w_alu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_live_reg <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      w_rf_wen   <= 1'b0;
      w_rf_waddr <= '0;
      w_rf_wdata <= '0;
    end else begin
      q_live_reg <= q_live_next;
      if (enq) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (deq) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      if (ld_go) begin
        w_rf_wen   <= 1'b1;
        w_rf_waddr <= w_ld_waddr;
        w_rf_wdata <= w_ld_wdata;
      end else if (deq) begin
        // A squashed head still consumes its slot but writes nothing.
        w_rf_wen <= q_live_reg[head_reg];
        if (q_live_reg[head_reg]) begin
          w_rf_waddr <= q_addr_reg[head_reg];
          w_rf_wdata <= q_data_reg[head_reg];
        end
      end else if (alu_go) begin
        w_rf_wen   <= 1'b1;
        w_rf_waddr <= w_alu_waddr;
        w_rf_wdata <= w_alu_wdata;
      end else begin
        w_rf_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Bench for reg_file_wb_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_reg_file_wb_arbiter;

  localparam int QDEPTH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              w_alu_valid = 1'b0;
  logic [ADDR_W-1:0] w_alu_waddr = '0;
  logic [DATA_W-1:0] w_alu_wdata = '0;
  logic              w_ld_valid = 1'b0;
  logic [ADDR_W-1:0] w_ld_waddr = '0;
  logic [DATA_W-1:0] w_ld_wdata = '0;
  logic              w_alu_stall;
  logic              w_rf_wen;
  logic [ADDR_W-1:0] w_rf_waddr;
  logic [DATA_W-1:0] w_rf_wdata;
  logic [NREG-1:0]   w_busy_mask;
  logic [2:0]        w_q_count;

  always #5 clock = ~clock;

  reg_file_wb_arbiter #(.QDEPTH(QDEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .w_alu_valid(w_alu_valid), .w_alu_waddr(w_alu_waddr), .w_alu_wdata(w_alu_wdata),
    .w_ld_valid(w_ld_valid), .w_ld_waddr(w_ld_waddr), .w_ld_wdata(w_ld_wdata),
    .w_alu_stall(w_alu_stall), .w_rf_wen(w_rf_wen), .w_rf_waddr(w_rf_waddr),
    .w_rf_wdata(w_rf_wdata), .w_busy_mask(w_busy_mask), .w_q_count(w_q_count)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                live;
  } ent_t;

  ent_t              mq[$];
  logic              m_wen;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rf [NREG];
  logic [DATA_W-1:0] d_rf [NREG];
  bit                armed = 0;
  bit                m_alu_taken;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREG-1:0] m_busy();
    logic [NREG-1:0] b = '0;
    foreach (mq[i]) if (mq[i].live) b[mq[i].a] = 1'b1;
    return b;
  endfunction

  task automatic compare_all();
    chk("rf_wen", w_rf_wen, m_wen);
    chk("rf_waddr", w_rf_waddr, m_waddr);
    chk("rf_wdata", w_rf_wdata, m_wdata);
    chk("q_count", w_q_count, mq.size());
    chk("busy_mask", w_busy_mask, m_busy());
    chk("alu_stall", w_alu_stall, mq.size() == QDEPTH);
    if (w_rf_wen === 1'b1) d_rf[w_rf_waddr] = w_rf_wdata;
  endtask

  task automatic model_step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                            input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bit   ld_go  = lv && (la != 0);
    bit   alu_ok = av && (mq.size() < QDEPTH) && (aa != 0);
    ent_t e;
    m_alu_taken = av && (mq.size() < QDEPTH);
    if (ld_go) begin
      m_wen = 1; m_waddr = la; m_wdata = ld;
      foreach (mq[i]) if (mq[i].a == la) mq[i].live = 0;
      if (alu_ok) mq.push_back('{aa, ad, 1'b1});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = e.live;
      if (e.live) begin m_waddr = e.a; m_wdata = e.d; end
      if (alu_ok) mq.push_back('{aa, ad, 1'b1});
    end else if (alu_ok) begin
      m_wen = 1; m_waddr = aa; m_wdata = ad;
    end else begin
      m_wen = 0;
    end
    if (m_wen) m_rf[m_waddr] = m_wdata;
  endtask

  task automatic tick(input bit rst,
                      input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    @(negedge clock);
    if (armed) compare_all();
    reset = rst;
    w_alu_valid = av; w_alu_waddr = aa; w_alu_wdata = ad;
    w_ld_valid = lv;  w_ld_waddr = la;  w_ld_wdata = ld;
    if (rst) begin
      mq.delete();
      m_wen = 0; m_waddr = '0; m_wdata = '0;
      m_alu_taken = 0;
      armed = 1;
    end else begin
      model_step(av, aa, ad, lv, la, ld);
    end
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Samples the DUT just after the edge that consumes the previous tick's inputs.
  task automatic post();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit                av, lv, rst;
    logic [ADDR_W-1:0] aa, la;
    logic [DATA_W-1:0] ad, ld;

    for (int i = 0; i < NREG; i++) begin m_rf[i] = '0; d_rf[i] = '0; end

    tick(1, 0, 0, 0, 0, 0, 0);
    post();
    chk("reset_wen", w_rf_wen, 0);
    chk("reset_count", w_q_count, 0);
    chk("reset_busy", w_busy_mask, 0);
    chk("reset_stall", w_alu_stall, 0);
    chk("reset_waddr", w_rf_waddr, 0);

    tick(0, 1, 5, 32'h11, 0, 0, 0);
    post();
    chk("bypass_wen", w_rf_wen, 1);
    chk("bypass_waddr", w_rf_waddr, 5);
    chk("bypass_wdata", w_rf_wdata, 32'h11);
    chk("bypass_count", w_q_count, 0);

    tick(0, 1, 7, 32'hBB, 1, 7, 32'hAA);
    post();
    chk("collide_ld", {w_rf_wen, w_rf_waddr, w_rf_wdata}, {1'b1, 5'd7, 32'hAA});
    chk("collide_busy1", w_busy_mask, 32'h80);
    idle();
    post();
    chk("collide_alu", {w_rf_wen, w_rf_waddr, w_rf_wdata}, {1'b1, 5'd7, 32'hBB});
    chk("collide_busy2", w_busy_mask, 0);

    for (int i = 1; i <= 4; i++) tick(0, 1, 5'(i), 32'(i), 1, 5'(10 + i), 32'h100 + 32'(i));
    post();
    chk("fill_count", w_q_count, 4);
    chk("fill_stall", w_alu_stall, 1);
    chk("fill_busy", w_busy_mask, 32'h1E);
    tick(0, 1, 9, 32'h99, 0, 0, 0);
    post();
    chk("drain_r1", {w_rf_wen, w_rf_waddr}, {1'b1, 5'd1});
    chk("stalled_ignored", w_q_count, 3);
    tick(0, 1, 9, 32'h99, 0, 0, 0);
    post();
    chk("drain_r2", {w_rf_wen, w_rf_waddr}, {1'b1, 5'd2});
    chk("r9_enq_count", w_q_count, 3);
    idle(); post(); chk("drain_r3", {w_rf_wen, w_rf_waddr}, {1'b1, 5'd3});
    idle(); post(); chk("drain_r4", {w_rf_wen, w_rf_waddr}, {1'b1, 5'd4});
    idle(); post(); chk("drain_r9", {w_rf_wen, w_rf_waddr, w_rf_wdata}, {1'b1, 5'd9, 32'h99});
    chk("drain_empty", w_q_count, 0);

    tick(0, 1, 3, 32'h1, 1, 8, 32'h55);
    post();
    chk("squash_busy_pre", w_busy_mask, 32'h08);
    tick(0, 0, 0, 0, 1, 3, 32'h2);
    post();
    chk("squash_ld", {w_rf_wen, w_rf_waddr, w_rf_wdata}, {1'b1, 5'd3, 32'h2});
    chk("squash_busy", w_busy_mask, 0);
    chk("squash_count", w_q_count, 1);
    idle();
    post();
    chk("squash_slot_wen", w_rf_wen, 0);
    chk("squash_slot_count", w_q_count, 0);

    tick(0, 1, 0, 32'hFF, 1, 0, 32'hEE);
    post();
    chk("zero_wen", w_rf_wen, 0);
    chk("zero_count", w_q_count, 0);
    chk("zero_busy", w_busy_mask, 0);

    tick(0, 1, 11, 32'h2, 1, 10, 32'h1);
    tick(0, 1, 13, 32'h4, 1, 12, 32'h3);
    tick(0, 1, 15, 32'h6, 1, 14, 32'h5);
    post();
    chk("mid_count", w_q_count, 3);
    tick(1, 0, 0, 0, 0, 0, 0);
    post();
    chk("mid_reset", {w_rf_wen, w_q_count, w_busy_mask, w_alu_stall}, 0);
    idle();
    post();
    chk("no_stale_wen", w_rf_wen, 0);

    av = 0; aa = '0; ad = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(av && !m_alu_taken)) begin
        av = ($urandom_range(0, 99) < 70);
        aa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      lv = ($urandom_range(0, 99) < (((cyc / 64) % 2) ? 85 : 20));
      la = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ld = $urandom;
      tick(rst, av, aa, ad, lv, la, ld);
      if (rst) av = 0;
    end
    for (int i = 0; i < 8; i++) idle();
    @(negedge clock);
    compare_all();
    for (int i = 0; i < NREG; i++) chk($sformatf("final_r%0d", i), d_rf[i], m_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_wb_arbiter.md
Name: reg_file_wb_arbiter

Overview:
- Schedules the register file's single write port between two producers: ALU writeback and load-data return from memory.
- Loads can never be stalled, so they always win the port. Displaced ALU results wait in a small in-order queue.
- Exports a busy mask of registers with queued writes so the issue/hazard logic can stall dependent reads.
- Sits between the EX/MEM stages and the register file write port, downstream of the write-address/enable decode.

Parameters:
- QDEPTH, 4, number of ALU writeback queue entries (power of 2, ≥2)
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- w_alu_valid  in  1  ALU result available this cycle
- w_alu_waddr  in  ADDR_W  ALU destination register
- w_alu_wdata  in  DATA_W  ALU result
- w_ld_valid  in  1  load data returning this cycle
- w_ld_waddr  in  ADDR_W  load destination register
- w_ld_wdata  in  DATA_W  load data
- w_alu_stall  out  1  queue full; ALU producer must hold its request
- w_rf_wen  out  1  register file write enable (registered)
- w_rf_waddr  out  ADDR_W  register file write address (registered)
- w_rf_wdata  out  DATA_W  register file write data (registered)
- w_busy_mask  out  2**ADDR_W  bit i=1 when a live queued write targets register i
- w_q_count  out  clog2(QDEPTH)+1  queue occupancy, including squashed entries

Behaviour:
- Reset (synchronous): queue empty, count 0, all entry live bits 0. w_rf_wen=0, w_rf_waddr=0, w_rf_wdata=0, w_busy_mask=0, w_alu_stall=0. Reset mid-operation discards all queued writes.
- A request whose address is 0 is dropped: no port write, no enqueue, no squash.
- w_alu_stall = (count == QDEPTH), driven combinationally from registered count only. An ALU request presented while stall=1 is ignored; the producer holds it.
- Port selection, evaluated each cycle; result registered, so latency is 1 cycle:
  1. w_ld_valid → port takes the load. A non-stalled ALU request is enqueued.
  2. Else if queue non-empty → head is dequeued to the port. If the head is squashed, w_rf_wen=0 and the slot is still consumed. A non-stalled ALU request is enqueued at the tail.
  3. Else if w_alu_valid → port takes the ALU request directly (bypass, no enqueue).
  4. Else w_rf_wen=0. waddr/wdata hold their previous values.
- Arrival order is program order:
  - A load arriving with address A clears the live bit of every queued entry whose address is A; the load value is newer.
  - When ALU and load arrive in the same cycle, the ALU result is younger. It is enqueued, never squashed by that load, and writes after the load.
- Simultaneous enqueue and dequeue in the same cycle: count unchanged. Enqueue with count==QDEPTH never occurs because stall is asserted.
- Queue is a circular buffer; head and tail pointers wrap modulo QDEPTH.
- w_busy_mask is the OR over live entries of onehot(waddr), computed from registered state. Bit 0 is always 0. An in-flight registered port write does not set a busy bit; the hazard unit covers it through its forwarding path.
- Queued entries with the same address drain in FIFO order, so the last-enqueued value lands last.

Test Plan:
- ALU only, empty queue: alu_valid, waddr=5, wdata=0x11 → next cycle rf_wen=1, waddr=5, wdata=0x11; q_count stays 0.
- Load+ALU collide: ld(7,0xAA) and alu(7,0xBB) in the same cycle → cycle+1 writes (7,0xAA); cycle+2 writes (7,0xBB); busy_mask[7]=1 for exactly one cycle.
- Fill/stall: 4 consecutive load cycles each with an ALU request to r1..r4 → q_count reaches 4, alu_stall=1, a held alu(r9) is ignored. After the loads stop, the queue drains r1..r4 in order, then r9 is accepted once stall drops.
- Squash: queue holds alu(3,0x1); then ld(3,0x2) → port writes (3,0x2), busy_mask[3]=0. The squashed slot later dequeues with rf_wen=0; final r3=0x2.
- Zero register: alu(0,0xFF) and ld(0,0xEE) → no write, q_count unchanged, busy_mask=0.
- Reset mid-drain: queue at count 3, assert reset for 1 cycle → next cycle rf_wen=0, q_count=0, busy_mask=0, stall=0; no stale writes afterwards.
